instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit for the RISC-V core. It is the reading side of the 256x32 instruction ROM (`rom256x32bit`). It holds the program counter and drives the ROM word address. The combinational ROM data is captured into a 2-entry buffer and handed to decode over a valid/ready handshake. Decode/execute can redirect the PC for branches and jumps.

## Interface
- `WIDTH`, 32, instruction width; must equal the ROM data width.
- `ADDR_W`, 8, ROM word-address width (256 words).
- `RESET_PC`, 32'h0000_0000, byte address fetched first after reset; bits [1:0] must be 0.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fetch_en`  in  1  1 = fetch; 0 = stop issuing new fetches (buffer still drains).
- `rom_addr`  out  ADDR_W  word address to the ROM; equals `pc[ADDR_W+1:2]`.
- `rom_data`  in  WIDTH  ROM word at `rom_addr`, valid in the same cycle (combinational ROM).
- `instr`  out  WIDTH  instruction at buffer head.
- `instr_pc`  out  32  byte address of `instr`; bits [1:0] = 0; bits above ADDR_W+1 = 0.
- `instr_valid`  out  1  buffer non-empty and no redirect this cycle.
- `instr_ready`  in  1  decode accepts; a transfer happens when `instr_valid & instr_ready`.
- `redirect_valid`  in  1  one-cycle request to load a new PC.
- `redirect_pc`  in  32  target byte address.
- `misalign`  out  1  registered one-cycle pulse: the last redirect target had bits [1:0] != 0.

## Operation
- FSM with two states, IDLE and RUN. Reset state is IDLE.
  - IDLE -> RUN when `fetch_en`=1.
  - RUN -> IDLE when `fetch_en`=0.
- Fetch condition at a clock edge:
  - state RUN, and
  - count<2, or count==2 with a transfer this cycle, and
  - no redirect.
- On fetch: push {`rom_data`, pc} into the buffer; `pc` <= pc+4.
  - Word index wraps modulo 2^ADDR_W: 0x3FC -> 0x000.
- Buffer: 2-entry FIFO with count 0..2.
  - Push and pop in the same cycle leave the count unchanged.
  - No entry is ever lost or duplicated.
- Redirect, aligned target (`redirect_pc[1:0]`==0), at the next edge:
  - buffer flushed (count=0);
  - `pc` <= {redirect_pc[ADDR_W+1:2], 2'b00};
  - upper target bits are ignored;
  - no fetch and no pop in that cycle.
- Redirect, misaligned target:
  - ignored; pc and buffer are unchanged;
  - `misalign`=1 for exactly the next cycle.
- `instr_valid` = (count!=0) & ~`redirect_valid`. The redirect masking is combinational, so no transfer can occur in a redirect cycle.
- `fetch_en`=0 mid-stream: buffered entries remain valid and drain normally. The PC holds its value.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - pc=`RESET_PC`, so `rom_addr`=RESET_PC[ADDR_W+1:2];
  - count=0, `instr_valid`=0, `instr`=0, `instr_pc`=0;
  - `misalign`=0, state IDLE.
- First fetch at the first edge where `fetch_en` is high after reset release. That edge moves the FSM to RUN and fetches in the same edge.
  - `instr_valid` rises one cycle after that edge.
- Fetch-to-decode latency is 1 cycle. With `instr_ready` held at 1, throughput is 1 instruction per cycle.
- Redirect latency:
  - redirect at edge N;
  - target fetched at edge N+1;
  - target instruction valid during cycle N+1..N+2.
  - That is 2 bubble cycles.
- Backpressure: with `instr_ready`=0, the buffer fills in 2 cycles, then `pc` stalls. When ready returns, data resumes with no bubble.
- Reset asserted mid-operation: everything returns immediately to the reset values; the buffer contents are discarded.

## Structure
- Shared package `rv_pkg`: `INSTR_W`=32, `ROM_ADDR_W`=8, `RESET_PC`, and the FSM state encoding `fetch_state_t` (IDLE, RUN).
- Sub-module `fetch_fifo2`: a 2-entry FIFO of width WIDTH+32 with push/pop/flush ports, count, and head output. The top level contains the PC, the FSM, and the redirect/misalign logic.
- The bench instantiates `rom256x32bit` loaded with word i = 32'hA500_0000 | i.

## Test plan
- Reset release, `fetch_en`=1, `instr_ready`=1 -> `instr_pc` = 0x0, 0x4, 0x8 on consecutive cycles; `instr` = A5000000, A5000001, A5000002.
- `instr_ready`=0 for 5 cycles after the first valid -> count saturates at 2 and `rom_addr` holds at 2. On ready, the stream resumes 0x0, 0x4, 0x8, 0xC with no gaps.
- Redirect to 0x100 while 2 entries are buffered -> `instr_valid`=0 for 2 cycles, then `instr_pc`=0x100, `instr`=A5000040; the flushed entries are never delivered.
- Run from 0x3F8 -> delivered order 0x3F8, 0x3FC, 0x000, 0x004.
- Redirect to 0x42 -> `misalign`=1 for exactly one cycle; the sequential stream continues uninterrupted. A redirect to 0x1000_0040 instead -> next `instr_pc`=0x040.
- `rst_n` pulsed low mid-stream with the buffer full -> `instr_valid`=0 immediately. Fetch restarts at `RESET_PC` once `rst_n`=1.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the RISC-V core front end: instruction/ROM geometry,
// reset fetch address and the fetch FSM state encoding.
package rv_pkg;

    localparam int          INSTR_W    = 32;
    localparam int          ROM_ADDR_W = 8;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry FIFO holding {instruction, pc} pairs between ROM read and decode.
// Entry e0 is always the head; e1 only holds data when count is 2.
module fetch_fifo2 #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] head,
    output logic [1:0]    count
);

    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
    logic [1:0]    cnt;

    // The caller never pops an empty FIFO nor pushes a full one without a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0  <= '0;
            e1  <= '0;
            cnt <= 2'd0;
        end else if (flush) begin
            cnt <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) e0 <= din;
                    else             e1 <= din;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    e0  <= e1;
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        e0 <= din;
                    end else begin
                        e0 <= e1;
                        e1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = e0;
    assign count = cnt;

endmodule

// File: rtl/rom256x32bit.sv
// 256x32 instruction ROM, combinational read. Word i holds 32'hA500_0000 | i.
module rom256x32bit (
    input  logic [7:0]  addr,
    output logic [31:0] data
);

    assign data = 32'hA500_0000 | {24'h00_0000, addr};

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC, fetch FSM and redirect handling in front of a
// combinational instruction ROM, feeding decode through a 2-entry buffer.
module instr_fetch #(
    parameter int          WIDTH    = rv_pkg::INSTR_W,
    parameter int          ADDR_W   = rv_pkg::ROM_ADDR_W,
    parameter logic [31:0] RESET_PC = rv_pkg::RESET_PC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fetch_en,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [WIDTH-1:0]     rom_data,
    output logic [WIDTH-1:0]     instr,
    output logic [31:0]          instr_pc,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    output logic                 misalign,
    output rv_pkg::fetch_state_t dbg_state,
    output logic [1:0]           dbg_count
);

    import rv_pkg::*;

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [1:0]        count;
    logic [WIDTH+31:0] head;
    logic [31:0]       fetch_pc;
    logic              redirect_ok;
    logic              redirect_bad;
    logic              push;
    logic              pop;
    logic              misalign_q;
    logic              unused_redirect_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fetch_en)  state_d = RUN;
            RUN:     if (!fetch_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign redirect_ok  = redirect_valid & (redirect_pc[1:0] == 2'b00);
    assign redirect_bad = redirect_valid & (redirect_pc[1:0] != 2'b00);

    // Handshake: an entry moves to decode on a rising edge where
    // instr_valid & instr_ready; instr_valid does not wait on instr_ready,
    // and any redirect request masks it so nothing transfers that cycle.
    assign instr_valid = (count != 2'd0) & ~redirect_valid;
    assign pop         = instr_valid & instr_ready;

    // Gating on the next state lets the edge that enters RUN also fetch.
    assign push = (state_d == RUN) & ((count < 2'd2) | pop) & ~redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC[ADDR_W+1:2];
        end else if (redirect_ok) begin
            pc_q <= redirect_pc[ADDR_W+1:2];
        end else if (push) begin
            pc_q <= pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= redirect_bad;
    end

    always_comb begin
        fetch_pc               = '0;
        fetch_pc[ADDR_W+1:0]   = {pc_q, 2'b00};
    end

    fetch_fifo2 #(
        .DW(WIDTH + 32)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .flush(redirect_ok),
        .din  ({rom_data, fetch_pc}),
        .head (head),
        .count(count)
    );

    assign rom_addr  = pc_q;
    assign instr     = head[WIDTH+31:32];
    assign instr_pc  = head[31:0];
    assign misalign  = misalign_q;
    assign dbg_state = state_q;
    assign dbg_count = count;

    // Target bits above the ROM range are deliberately ignored.
    assign unused_redirect_bits = ^redirect_pc[31:ADDR_W+2];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch driving a 256x32 ROM whose word i is A500_0000|i.
module tb_instr_fetch;

    import rv_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         fetch_en;
    logic [7:0]   rom_addr;
    logic [31:0]  rom_data;
    logic [31:0]  instr;
    logic [31:0]  instr_pc;
    logic         instr_valid;
    logic         instr_ready;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         misalign;
    fetch_state_t dbg_state;
    logic [1:0]   dbg_count;

    int checks = 0;
    int passed = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    rom256x32bit u_rom (
        .addr(rom_addr),
        .data(rom_data)
    );

    instr_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en      (fetch_en),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .misalign      (misalign),
        .dbg_state     (dbg_state),
        .dbg_count     (dbg_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Checks queued pcs/instructions against transfers, bounded by budget cycles.
    task automatic drain_check(input int budget);
        logic [31:0] e;
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            if (instr_valid && instr_ready) begin
                e = exp_q.pop_front();
                chk("stream_pc", instr_pc, e);
                chk("stream_instr", instr, 32'hA500_0000 | {24'h0, e[9:2]});
            end
            tick();
            n++;
        end
        chk("stream_left", exp_q.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #3;
        chk("rst_valid", instr_valid, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_misalign", misalign, 32'd0);
        chk("rst_rom_addr", rom_addr, 32'h0);
        chk("rst_count", dbg_count, 32'd0);
        chk("rst_state", dbg_state, IDLE);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential stream with ready held high
        fetch_en    = 1'b1;
        instr_ready = 1'b1;
        tick();
        chk("run_state", dbg_state, RUN);
        for (int i = 0; i < 3; i++) begin
            chk("seq_valid", instr_valid, 32'd1);
            chk("seq_pc", instr_pc, 32'(i * 4));
            chk("seq_instr", instr, 32'hA500_0000 + 32'(i));
            tick();
        end

        // Backpressure: buffer fills, pc stalls, then no-gap resume
        do_reset();
        fetch_en    = 1'b1;
        instr_ready = 1'b0;
        tick();
        chk("bp_first_valid", instr_valid, 32'd1);
        chk("bp_first_pc", instr_pc, 32'h0);
        repeat (4) tick();
        chk("bp_count", dbg_count, 32'd2);
        chk("bp_rom_addr", rom_addr, 32'd2);
        chk("bp_head_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_resume_valid", instr_valid, 32'd1);
            chk("bp_resume_pc", instr_pc, 32'(i * 4));
            tick();
        end

        // Aligned redirect with two entries buffered
        instr_ready = 1'b0;
        tick();
        tick();
        chk("rd_count_full", dbg_count, 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        #1;
        chk("rd_mask_valid", instr_valid, 32'd0);
        tick();
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        #1;
        chk("rd_bubble_valid", instr_valid, 32'd0);
        chk("rd_flush_count", dbg_count, 32'd0);
        tick();
        chk("rd_target_valid", instr_valid, 32'd1);
        chk("rd_target_pc", instr_pc, 32'h0000_0100);
        chk("rd_target_instr", instr, 32'hA500_0040);
        tick();
        chk("rd_next_pc", instr_pc, 32'h0000_0104);

        // Word index wrap at the top of the ROM
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_03F8;
        tick();
        redirect_valid = 1'b0;
        exp_q.push_back(32'h3F8);
        exp_q.push_back(32'h3FC);
        exp_q.push_back(32'h000);
        exp_q.push_back(32'h004);
        drain_check(12);

        // Misaligned redirect is ignored and pulses misalign once
        chk("mis_head_pc", instr_pc, 32'h008);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0042;
        #1;
        chk("mis_before", misalign, 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("mis_pulse", misalign, 32'd1);
        chk("mis_keep_pc", instr_pc, 32'h008);
        chk("mis_keep_valid", instr_valid, 32'd1);
        tick();
        chk("mis_clear", misalign, 32'd0);
        chk("mis_stream_pc", instr_pc, 32'h00C);

        // Upper target bits ignored
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1000_0040;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("upper_pc", instr_pc, 32'h040);
        chk("upper_instr", instr, 32'hA500_0010);

        // fetch_en low mid-stream: buffer drains, pc holds
        instr_ready = 1'b0;
        tick();
        tick();
        chk("stop_count", dbg_count, 32'd2);
        chk("stop_rom_addr", rom_addr, 32'h12);
        fetch_en    = 1'b0;
        instr_ready = 1'b1;
        #1;
        chk("stop_pc0", instr_pc, 32'h040);
        tick();
        chk("stop_pc1", instr_pc, 32'h044);
        chk("stop_state", dbg_state, IDLE);
        tick();
        chk("stop_empty", instr_valid, 32'd0);
        chk("stop_hold_addr", rom_addr, 32'h12);

        // Asynchronous reset with the buffer full
        fetch_en    = 1'b1;
        instr_ready = 1'b0;
        tick();
        tick();
        chk("ar_count_full", dbg_count, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", instr_valid, 32'd0);
        chk("ar_instr", instr, 32'h0);
        chk("ar_instr_pc", instr_pc, 32'h0);
        chk("ar_count", dbg_count, 32'd0);
        chk("ar_rom_addr", rom_addr, 32'h0);
        chk("ar_state", dbg_state, IDLE);
        @(negedge clk);
        rst_n       = 1'b1;
        instr_ready = 1'b1;
        tick();
        chk("ar_restart_valid", instr_valid, 32'd1);
        chk("ar_restart_pc", instr_pc, 32'h0);
        chk("ar_restart_instr", instr, 32'hA500_0000);
        tick();
        chk("ar_restart_pc1", instr_pc, 32'h4);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
